pc_sequencer: RTL and testbench

Fetch/update controller for the 32-bit program counter register. It steps the core through boot, instruction fetch, execute-wait and PC update. It drives the counter's load, increment, clear and data inputs, and runs a request/ready handshake with instruction memory. It sits between the program counter, instruction memory and the execute datapath, and is the only block that writes the PC.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter fetch/update sequencer: boot, fetch handshake, execute wait, PC update.
// Optional fetch watchdog enabled by defining PCSEQ_TIMEOUT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] pc_q,
  input  logic        imem_rdy,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic [31:0] pc_d,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOOT   = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic        halt_pend_reg;
  logic        br_taken_reg;
  logic [31:0] br_target_reg;
  logic        instr_valid_reg;

`ifdef PCSEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(FETCH_TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_hit;

  assign timeout_hit = (wait_cnt_reg == WAIT_W'(FETCH_TIMEOUT - 1));

  // Counter idles at zero outside FETCH, so it is already cleared on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt_reg <= '0;
    else if (state_reg != S_FETCH)
      wait_cnt_reg <= '0;
    else if (!imem_rdy)
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start && !halt) state_next = S_BOOT;
      S_BOOT:   state_next = S_FETCH;
      S_FETCH: begin
        if (imem_rdy)
          state_next = S_EXEC;
`ifdef PCSEQ_TIMEOUT_EN
        else if (timeout_hit)
          state_next = S_FAULT;
`endif
      end
      S_EXEC: begin
        if (exec_done)
          state_next = (br_taken && (br_target[1:0] != 2'b00)) ? S_FAULT : S_UPDATE;
      end
      S_UPDATE: state_next = halt_pend_reg ? S_IDLE : S_FETCH;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    instr_valid = instr_valid_reg;
    pc_ld       = 1'b0;
    pc_inc      = 1'b0;
    pc_clr      = 1'b0;
    pc_d        = 32'h0;
    fault       = 1'b0;
    case (state_reg)
      S_IDLE: pc_clr = 1'b1;
      S_BOOT: begin
        pc_ld = 1'b1;
        pc_d  = RESET_VECTOR;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      S_UPDATE: begin
        pc_ld  = 1'b1;
        pc_d   = br_taken_reg ? br_target_reg : pc_q;
        pc_inc = !br_taken_reg;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      halt_pend_reg   <= 1'b0;
      br_taken_reg    <= 1'b0;
      br_target_reg   <= 32'h0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      instr_valid_reg <= (state_reg == S_FETCH) && imem_rdy;
      if (state_next == S_IDLE)
        halt_pend_reg <= 1'b0;
      else if (halt && (state_reg != S_IDLE) && (state_reg != S_FAULT))
        halt_pend_reg <= 1'b1;
      if ((state_reg == S_EXEC) && exec_done) begin
        br_taken_reg  <= br_taken;
        br_target_reg <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, corner sequences and randomized instruction stream.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, halt = 1'b0, imem_rdy = 1'b0, exec_done = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;

  logic [31:0] pc_q, imem_addr, pc_d;
  logic        imem_req, instr_valid, pc_ld, pc_inc, pc_clr, fault;
  logic [2:0]  state;

  logic [31:0] w_pc_q, w_imem_addr, w_pc_d;
  logic        w_imem_req, w_instr_valid, w_pc_ld, w_pc_inc, w_pc_clr, w_fault;
  logic [2:0]  w_state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_q(pc_q),
    .imem_rdy(imem_rdy), .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr), .pc_d(pc_d),
    .fault(fault), .state(state)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_q(w_pc_q),
    .imem_rdy(imem_rdy), .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .instr_valid(w_instr_valid),
    .pc_ld(w_pc_ld), .pc_inc(w_pc_inc), .pc_clr(w_pc_clr), .pc_d(w_pc_d),
    .fault(w_fault), .state(w_state)
  );

  // Behavioural program counter: clr, then load (d, plus 4 when inc), then increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc_q <= 32'h0;
    else if (pc_clr) pc_q <= 32'h0;
    else if (pc_ld)  pc_q <= pc_d + (pc_inc ? 32'd4 : 32'd0);
    else if (pc_inc) pc_q <= pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          w_pc_q <= 32'h0;
    else if (w_pc_clr) w_pc_q <= 32'h0;
    else if (w_pc_ld)  w_pc_q <= w_pc_d + (w_pc_inc ? 32'd4 : 32'd0);
    else if (w_pc_inc) w_pc_q <= w_pc_q + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; imem_rdy = 0; exec_done = 0; br_taken = 0; br_target = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step();
    step();
    chk("rst_state", {29'h0, state}, 32'd0);
    chk("rst_clr", {31'h0, pc_clr}, 32'd1);
    chk("rst_fault", {31'h0, fault}, 32'd0);
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_ld", {31'h0, pc_ld}, 32'd0);
    chk("rst_pcd", pc_d, 32'h0);
    rst = 1;
  endtask

  typedef struct {
    logic        start, halt, rdy, done, taken;
    logic [31:0] target;
    logic [2:0]  st;
    logic        req;
    logic [31:0] addr;
    logic        valid, ld, inc, clr;
    logic [31:0] pcd;
    logic        flt;
  } vec_t;

  vec_t vecs[16];

  logic [31:0] exp_pc, pc_before, tgt;
  int          d, e;
  logic        tk, hlt;

  initial begin
    //          st ht rd dn tk target         st   req addr          v  ld inc clr pcd           flt
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        3'd1, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0};
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        3'd2, 1, 32'h0,        0, 0, 0, 0, 32'h0,        0};
    vecs[2]  = '{0, 0, 1, 0, 0, 32'h0,        3'd3, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0};
    vecs[3]  = '{0, 0, 0, 1, 1, 32'h100,      3'd4, 0, 32'h0,        0, 1, 0, 0, 32'h100,      0};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h0,        3'd2, 1, 32'h100,      0, 0, 0, 0, 32'h0,        0};
    vecs[5]  = '{0, 0, 1, 0, 0, 32'h0,        3'd3, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0};
    vecs[6]  = '{0, 0, 1, 0, 0, 32'h0,        3'd3, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0};
    vecs[7]  = '{0, 0, 0, 1, 0, 32'h55,       3'd4, 0, 32'h0,        0, 1, 1, 0, 32'h100,      0};
    vecs[8]  = '{0, 0, 0, 0, 0, 32'h0,        3'd2, 1, 32'h104,      0, 0, 0, 0, 32'h0,        0};
    vecs[9]  = '{0, 0, 0, 1, 0, 32'h0,        3'd2, 1, 32'h104,      0, 0, 0, 0, 32'h0,        0};
    vecs[10] = '{0, 0, 1, 0, 0, 32'h0,        3'd3, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0};
    vecs[11] = '{0, 1, 0, 0, 0, 32'h0,        3'd3, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0};
    vecs[12] = '{0, 0, 0, 1, 0, 32'h0,        3'd4, 0, 32'h0,        0, 1, 1, 0, 32'h104,      0};
    vecs[13] = '{0, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        0};
    vecs[14] = '{1, 1, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        0};
    vecs[15] = '{0, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        0};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      start = vecs[i].start; halt = vecs[i].halt; imem_rdy = vecs[i].rdy;
      exec_done = vecs[i].done; br_taken = vecs[i].taken; br_target = vecs[i].target;
      step();
      chk($sformatf("vec%0d_state", i), {29'h0, state}, {29'h0, vecs[i].st});
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].valid});
      chk($sformatf("vec%0d_ld", i), {31'h0, pc_ld}, {31'h0, vecs[i].ld});
      chk($sformatf("vec%0d_inc", i), {31'h0, pc_inc}, {31'h0, vecs[i].inc});
      chk($sformatf("vec%0d_clr", i), {31'h0, pc_clr}, {31'h0, vecs[i].clr});
      chk($sformatf("vec%0d_pcd", i), pc_d, vecs[i].pcd);
      chk($sformatf("vec%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].flt});
      $display("vec %0d: state=%0d req=%0b addr=%h ld=%0b inc=%0b pc_d=%h", i, state, imem_req, imem_addr, pc_ld, pc_inc, pc_d);
    end

    // Back-to-back 3-cycle instructions; the wrap instance boots at FFFF_FFFC.
    do_reset();
    imem_rdy = 1; exec_done = 1;
    start = 1;
    step();
    start = 0;
    chk("lat_boot_state", {29'h0, state}, 32'd1);
    chk("lat_boot_req", {31'h0, imem_req}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq%0d_req", i), {31'h0, imem_req}, 32'd1);
      chk($sformatf("seq%0d_addr", i), imem_addr, 32'(4 * i));
      if (i == 0) chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_addr1", w_imem_addr, 32'h0000_0000);
      $display("seq fetch %0d: addr=%h wrap_addr=%h", i, imem_addr, w_imem_addr);
      step(); step(); step();
    end
    clear_inputs();

    // Misaligned taken branch after a good branch to 0x200.
    do_reset();
    start = 1; step(); start = 0; step();
    imem_rdy = 1; step(); imem_rdy = 0;
    exec_done = 1; br_taken = 1; br_target = 32'h200; step(); clear_inputs();
    step();
    chk("mis_fetch_addr", imem_addr, 32'h200);
    imem_rdy = 1; step(); imem_rdy = 0;
    pc_before = pc_q;
    exec_done = 1; br_taken = 1; br_target = 32'h102; step(); clear_inputs();
    chk("mis_fault", {31'h0, fault}, 32'd1);
    chk("mis_state", {29'h0, state}, 32'd5);
    chk("mis_ld", {31'h0, pc_ld}, 32'd0);
    start = 1; imem_rdy = 1; exec_done = 1;
    repeat (4) step();
    clear_inputs();
    chk("mis_sticky_state", {29'h0, state}, 32'd5);
    chk("mis_sticky_fault", {31'h0, fault}, 32'd1);
    chk("mis_pc_hold", pc_q, pc_before);
    chk("mis_req", {31'h0, imem_req}, 32'd0);
    $display("misaligned: state=%0d fault=%0b pc=%h", state, fault, pc_q);
    rst = 0; #1;
    chk("mis_rst_state", {29'h0, state}, 32'd0);
    step(); rst = 1;

    // Asynchronous reset while in UPDATE.
    do_reset();
    start = 1; step(); start = 0; step();
    imem_rdy = 1; step(); imem_rdy = 0;
    exec_done = 1; step(); exec_done = 0;
    chk("ar_upd_ld", {31'h0, pc_ld}, 32'd1);
    #2 rst = 0; #1;
    chk("ar_state", {29'h0, state}, 32'd0);
    chk("ar_ld", {31'h0, pc_ld}, 32'd0);
    chk("ar_clr", {31'h0, pc_clr}, 32'd1);
    $display("async reset in update: state=%0d ld=%0b", state, pc_ld);
    step(); rst = 1;

`ifdef PCSEQ_TIMEOUT_EN
    do_reset();
    start = 1; step(); start = 0; step();
    repeat (15) step();
    chk("to_still_fetch", {29'h0, state}, 32'd2);
    step();
    chk("to_state", {29'h0, state}, 32'd5);
    chk("to_fault", {31'h0, fault}, 32'd1);
    $display("timeout: state=%0d fault=%0b", state, fault);
    do_reset();
    start = 1; step(); start = 0; step();
    repeat (15) step();
    imem_rdy = 1; step(); imem_rdy = 0;
    chk("to_rdy16_state", {29'h0, state}, 32'd3);
    chk("to_rdy16_fault", {31'h0, fault}, 32'd0);
    $display("timeout edge rdy: state=%0d fault=%0b", state, fault);
`else
    do_reset();
    start = 1; step(); start = 0; step();
    repeat (40) step();
    chk("nowd_state", {29'h0, state}, 32'd2);
    chk("nowd_fault", {31'h0, fault}, 32'd0);
    $display("no watchdog: state=%0d after 40 wait cycles", state);
`endif

    // Randomized instruction stream against a PC-arithmetic model.
    do_reset();
    start = 1; step(); start = 0; step();
    exp_pc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      d   = $urandom_range(0, 5);
      e   = $urandom_range(0, 4);
      tk  = ($urandom_range(0, 2) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
      hlt = ($urandom_range(0, 7) == 0);
      chk("rnd_fetch_state", {29'h0, state}, 32'd2);
      chk("rnd_fetch_addr", imem_addr, exp_pc);
      for (int j = 0; j < d; j++) begin
        step();
        chk("rnd_addr_stable", imem_addr, exp_pc);
        chk("rnd_req_held", {31'h0, imem_req}, 32'd1);
      end
      imem_rdy = 1; step(); imem_rdy = 0;
      chk("rnd_valid", {31'h0, instr_valid}, 32'd1);
      chk("rnd_exec_req", {31'h0, imem_req}, 32'd0);
      for (int j = 0; j < e; j++) begin
        halt = hlt && (j == 0);
        step();
        halt = 0;
        chk("rnd_valid_low", {31'h0, instr_valid}, 32'd0);
        chk("rnd_exec_state", {29'h0, state}, 32'd3);
      end
      if (e == 0) halt = hlt;
      exec_done = 1; br_taken = tk; br_target = tgt;
      step();
      clear_inputs();
      chk("rnd_upd_state", {29'h0, state}, 32'd4);
      chk("rnd_upd_inc", {31'h0, pc_inc}, {31'h0, !tk});
      chk("rnd_upd_pcd", pc_d, tk ? tgt : exp_pc);
      exp_pc = tk ? tgt : exp_pc + 32'd4;
      step();
      $display("rnd %0d: wait=%0d exec=%0d taken=%0b halt=%0b next_pc=%h", n, d, e, tk, hlt, exp_pc);
      if (hlt) begin
        chk("rnd_halt_state", {29'h0, state}, 32'd0);
        chk("rnd_halt_clr", {31'h0, pc_clr}, 32'd1);
        start = 1; step(); start = 0; step();
        exp_pc = 32'h0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
